// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// The sub field exists only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef PIPELINED_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
`ifdef PIPELINED_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder, one STAGE_BITS ripple segment per register stage.
// Define PIPELINED_ADDER_SUB_EN to add a per-beat subtract control (bus.sub).
module pipelined_adder #(
  parameter int WIDTH      = 16,
  parameter int STAGE_BITS = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave bus
);
  localparam int NUM_STAGES = WIDTH / STAGE_BITS;

  if (WIDTH < 2 || STAGE_BITS < 1 || (WIDTH % STAGE_BITS) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 2 and an exact multiple of STAGE_BITS");
  end

  logic                  w_sub;
  logic [NUM_STAGES-1:0] w_v;
  logic [NUM_STAGES-1:0] w_stage_ready;

`ifdef PIPELINED_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // A stage can load when it is empty or its successor can take its beat.
  always_comb begin
    logic w_rdy;
    w_rdy = bus.out_ready;
    w_stage_ready = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      w_rdy = !w_v[k] || w_rdy;
      w_stage_ready[k] = w_rdy;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
    localparam int LO   = k * STAGE_BITS;
    localparam int REM  = WIDTH - LO;
    localparam bit LAST = (k == NUM_STAGES - 1);

    logic [REM-1:0]           w_a_rem;
    logic [REM-1:0]           w_b_rem;
    logic [STAGE_BITS-1:0]    w_b_eff;
    logic [STAGE_BITS-1:0]    w_sum_seg;
    logic [LO+STAGE_BITS-1:0] w_s_nxt;
    logic                     w_c_in;
    logic                     w_c_out;
    logic                     w_v_in;
    logic                     w_sub_in;
    logic                     w_load;
    logic [LO+STAGE_BITS-1:0] r_s;
    logic                     r_c;
    logic                     r_v;

    if (k == 0) begin : g_src
      assign w_a_rem  = bus.a;
      assign w_b_rem  = bus.b;
      assign w_c_in   = bus.cin;
      assign w_v_in   = bus.in_valid;
      assign w_sub_in = w_sub;
      assign w_s_nxt  = w_sum_seg;
    end else begin : g_src
      assign w_a_rem  = g_st[k-1].g_fwd.r_a;
      assign w_b_rem  = g_st[k-1].g_fwd.r_b;
      assign w_c_in   = g_st[k-1].r_c;
      assign w_v_in   = g_st[k-1].r_v;
      assign w_sub_in = g_st[k-1].g_fwd.r_sub;
      assign w_s_nxt  = {w_sum_seg, g_st[k-1].r_s};
    end

    // b is inverted segment by segment so the sub flag rides along with its beat.
    assign w_b_eff  = w_b_rem[STAGE_BITS-1:0] ^ {STAGE_BITS{w_sub_in}};
    assign w_load   = w_stage_ready[k] && w_v_in;
    assign w_v[k]   = r_v;

    always_comb begin
      logic w_c;
      w_c = w_c_in;
      w_sum_seg = '0;
      for (int i = 0; i < STAGE_BITS; i++) begin
        w_sum_seg[i] = w_a_rem[i] ^ w_b_eff[i] ^ w_c;
        w_c = (w_a_rem[i] & w_b_eff[i]) | (w_c & (w_a_rem[i] ^ w_b_eff[i]));
      end
      w_c_out = w_c;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else begin
        if (w_stage_ready[k]) r_v <= w_v_in;
        if (w_load) begin
          r_s <= w_s_nxt;
          r_c <= w_c_out;
        end
      end
    end

    if (!LAST) begin : g_fwd
      logic [REM-STAGE_BITS-1:0] r_a;
      logic [REM-STAGE_BITS-1:0] r_b;
      logic                      r_sub;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_sub <= 1'b0;
        end else if (w_load) begin
          r_a   <= w_a_rem[REM-1:STAGE_BITS];
          r_b   <= w_b_rem[REM-1:STAGE_BITS];
          r_sub <= w_sub_in;
        end
      end
    end else begin : g_last
      logic r_cmsb;

      // Carry into the MSB recovered from the MSB's own sum bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cmsb <= 1'b0;
        end else if (w_load) begin
          r_cmsb <= w_a_rem[STAGE_BITS-1] ^ w_b_eff[STAGE_BITS-1] ^ w_sum_seg[STAGE_BITS-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_stage_ready[0];
  assign bus.out_valid = g_st[NUM_STAGES-1].r_v;
  assign bus.s         = g_st[NUM_STAGES-1].r_s;
  assign bus.cout      = g_st[NUM_STAGES-1].r_c;
  assign bus.ovf       = g_st[NUM_STAGES-1].r_c ^ g_st[NUM_STAGES-1].g_last.r_cmsb;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGE_BITS=4).
// Subtract cases run only when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_out = 0;
  int     n_in = 0;
  int     n_flushed = 0;
  int     base;
  int     found;
  bit     rand_done;
  logic [W-1:0] held;
  exp_t   q[$];

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGE_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain integer addition on the effective operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] be;
    int unsigned  total;
    be     = sub ? ~b : b;
    total  = 32'(a) + 32'(be) + 32'(cin);
    e.s    = total[W-1:0];
    e.cout = total[W];
    e.ovf  = (a[W-1] == be[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub      = sub;
`endif
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        q.push_back(model(a, b, cin, sub));
        n_in++;
        align();
        bus.in_valid = 1'b0;
        return;
      end
      align();
    end
    bus.in_valid = 1'b0;
    bound_fail("send_accept");
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (q.size() == 0) return;
      align();
    end
    bound_fail("drain");
  endtask

  task automatic latency_check(input string name);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(name, 32'(bus.out_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    align();
  endtask

  // Monitor: pops the scoreboard whenever a result beat is consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got s=0x%0h, required no beat", bus.s);
        end else begin
          e = q.pop_front();
          check("result_s", 32'(bus.s), 32'(e.s));
          check("result_cout", 32'(bus.cout), 32'(e.cout));
          check("result_ovf", 32'(bus.ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_s", 32'(bus.s), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    align();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    align();

    // Basic add and latency
    bus.out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    latency_check("t1_latency");
    drain();

    // Carry across all segments, signed overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    send(16'h00FF, 16'h0000, 1'b1, 1'b0);
    drain();

    // Back-to-back beats emerge on consecutive cycles
    base = n_out;
    for (int i = 0; i < 8; i++) send(16'(i), 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_consecutive_valid", 32'(bus.out_valid), (i < 4) ? 32'd1 : 32'd0);
    end
    align();
    check("t3_out_count", 32'(n_out - base), 32'd8);

    // Backpressure after the second result
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(16'h0020 + i), 16'h0100, 1'b0, 1'b0);
      end
      begin
        found = 0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (n_out >= base + 2) begin
            found = 1;
            break;
          end
        end
        if (found == 0) bound_fail("t3_wait_two_results");
        align();
        bus.out_ready = 1'b0;
        found = 0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (!bus.in_ready) begin
            found = 1;
            break;
          end
        end
        check("t3_in_ready_fell", 32'(found), 32'd1);
        check("t3_full_out_valid", 32'(bus.out_valid), 32'd1);
        held = bus.s;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t3_stall_s_stable", 32'(bus.s), 32'(held));
          check("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        align();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t3_no_loss_no_dup", 32'(n_out - base), 32'd8);

    // Bubbles collapse under a stalled output
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    check("t4_ready_1", 32'(bus.in_ready), 32'd1);
    check("t4_valid_held", 32'(bus.out_valid), 32'd1);
    check("t4_s_held", 32'(bus.s), 32'h3333);
    align();
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    check("t4_ready_2", 32'(bus.in_ready), 32'd1);
    check("t4_s_held", 32'(bus.s), 32'h3333);
    align();
    send(16'h0404, 16'h0505, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    check("t4_ready_3", 32'(bus.in_ready), 32'd1);
    align();
    send(16'h0606, 16'h0707, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
    check("t4_valid_held", 32'(bus.out_valid), 32'd1);
    check("t4_s_held", 32'(bus.s), 32'h3333);
    align();
    bus.out_ready = 1'b1;
    drain();

    // Reset with beats in flight
    send(16'h0A0A, 16'h0101, 1'b0, 1'b0);
    send(16'h0B0B, 16'h0101, 1'b0, 1'b0);
    send(16'h0C0C, 16'h0101, 1'b0, 1'b0);
    rst = 1'b1;
    n_flushed += q.size();
    q.delete();
    align();
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_s", 32'(bus.s), 32'd0);
    check("t5_cout", 32'(bus.cout), 32'd0);
    check("t5_ovf", 32'(bus.ovf), 32'd0);
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    align();
    send(16'h0002, 16'h0003, 1'b0, 1'b0);
    latency_check("t5_latency");
    idle(10);
    drain();

`ifdef PIPELINED_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h1234, 16'h1234, 1'b0, 1'b1);
    drain();
`endif

    // Randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
`ifdef PIPELINED_ADDER_SUB_EN
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
`endif
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          align();
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    check("final_queue_empty", 32'(q.size()), 32'd0);
    check("final_beat_count", 32'(n_out), 32'(n_in - n_flushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined two's-complement adder. It is the successor to the 4-bit ripple-carry fulladder chain.
- The carry chain is split into STAGE_BITS-wide segments, with one register stage per segment. Each segment is a ripple of single-bit full-adder cells.
- A valid/ready handshake with backpressure lets it sit between streaming datapath blocks.
- Throughput is one operation per clock at any WIDTH.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be >= 2.
- STAGE_BITS, 4, bits resolved per pipeline stage; must divide WIDTH exactly.
- NUM_STAGES (localparam) = WIDTH/STAGE_BITS, pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum, registered
- cout  output  1  carry-out of MSB
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset: one clock; the reset is synchronous and active-high, asserted on rst at the rising edge of clk. rst=1 clears all stage valid bits. Output values during and after reset:
  - out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after reset.
  - Data registers are cleared to 0.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Accept: a beat is accepted on a clock edge where in_valid && in_ready.
- Emit: a beat is consumed on a clock edge where out_valid && out_ready.
- Stage k (0..NUM_STAGES-1) function:
  - Adds bits [k*STAGE_BITS +: STAGE_BITS] of a and b, plus the registered carry from stage k-1 (cin for k=0).
  - Registers that segment's sum and carry-out.
- Operand skew: bits above the current segment are carried forward unchanged in stage registers.
- Result de-skew: already-computed lower sum bits are carried forward unchanged.
- Last stage: also registers the carry into the MSB, which is needed for ovf.
- Latency: NUM_STAGES cycles from accept to out_valid, with out_ready held high (4 cycles at defaults).
- Stage handshake: each stage holds a valid bit v[k]. stage_ready[k] = !v[k] || stage_ready[k+1], with stage_ready[NUM_STAGES-1] = !v[last] || out_ready.
  - in_ready = stage_ready[0].
  - No combinational path from in_valid to in_ready.
- Advance: stage k loads from stage k-1 when stage_ready[k]. v[k] then takes v[k-1], or in_valid && in_ready for stage 0.
  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
- Stall: while out_valid && !out_ready, s/cout/ovf and out_valid hold stable.
- Full: when all stages are valid and out_ready=0, in_ready=0.
- Simultaneous accept and emit with a full pipeline is legal; throughput is maintained.
- Ordering: strictly FIFO; no reordering and no dropping.
- Arithmetic is modulo 2^WIDTH.
  - cout is the unsigned carry out of the MSB.
  - ovf is set only when a and b have equal sign and s differs from it. This is computed with the effective b, which is ~b in subtract mode.
- Parameter check: an invalid parameter set (WIDTH % STAGE_BITS != 0) stops elaboration via a generate-time error.

Optional Feature:
- PIPELINED_ADDER_SUB_EN
- Defined:
  - Adds input port `sub` (1 bit), captured with each accepted beat.
  - sub=1 computes a - b - !cin, using b inverted and carry-in forced to the inverted sense; the caller drives cin=1 for a plain a-b.
  - cout=1 means no borrow.
  - ovf uses signed subtraction rules.
  - sub travels with its beat through every stage.
- Undefined: the port is absent and the block only adds; behaviour is identical to sub=0.

Test Plan (WIDTH=16, STAGE_BITS=4):
1. a=0x1234, b=0x4321, cin=0, out_ready=1 -> s=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0 (carry crosses all stage boundaries). Also a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
3. 8 back-to-back beats a=i, b=0x0100 with out_ready=1 -> results 0x0100..0x0107 on consecutive cycles, in order. Then drop out_ready after result 2 -> in_ready falls once 4 beats are held; no beat is lost or duplicated after out_ready returns.
4. out_ready=0 with 1 beat in flight, then 3 further beats with gaps -> bubbles collapse; in_ready stays 1 until 4 beats are queued; output holds stable during the stall.
5. Assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0, s=0, in_ready=1. A fresh beat 0x0002+0x0003 yields 0x0005 after 4 cycles; no stale results appear.
6. (PIPELINED_ADDER_SUB_EN) sub=1, cin=1: a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
